// File: rtl/symbol_error_channel_pkg.sv
// Shared definitions for the symbol error channel: mode encodings, burst FSM
// states and default pseudorandom generator constants.
package rs_channel_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_RANDOM = 2'd1,
        MODE_BURST  = 2'd2,
        MODE_FIXED  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BURST = 2'd2,
        ST_DONE  = 2'd3
    } burst_st_e;

    localparam logic [15:0] DEF_LFSR_TAPS = 16'hB400;
    localparam logic [15:0] DEF_LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/symbol_error_channel_if.sv
// Valid-qualified symbol stream through the error channel: symbols in, possibly
// corrupted symbols out with error and start-of-codeword flags.
interface symbol_error_channel_if #(
    parameter int SYM_W = 8
);
    logic             in_valid;
    logic [SYM_W-1:0] in_data;
    logic             out_valid;
    logic [SYM_W-1:0] out_data;
    logic             out_err;
    logic             out_sop;

    modport master (
        output in_valid, in_data,
        input  out_valid, out_data, out_err, out_sop
    );

    modport slave (
        input  in_valid, in_data,
        output out_valid, out_data, out_err, out_sop
    );
endinterface

// File: rtl/symbol_error_channel_lfsr.sv
// Galois-form LFSR that steps once per enabled cycle; reusable for any
// test-pattern block needing a cheap pseudorandom source.
module lfsr_gen
    import rs_channel_pkg::*;
#(
    parameter int           W    = 16,
    parameter logic [W-1:0] TAPS = W'(DEF_LFSR_TAPS),
    parameter logic [W-1:0] SEED = W'(DEF_LFSR_SEED)
) (
    input  logic         clk_in,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] state
);

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state <= SEED;
        end else if (en) begin
            state <= state[0] ? ((state >> 1) ^ TAPS) : (state >> 1);
        end
    end

endmodule

// File: rtl/symbol_error_channel.sv
// Symbol error injector between RS encoder and decoder: tracks codeword
// position, applies bypass/random/burst/fixed corruption under a per-block cap.
//
// Burst FSM:
//   state    | meaning
//   ST_IDLE  | not in burst mode
//   ST_WAIT  | start drawn for this codeword, waiting for position == start
//   ST_BURST | corrupting consecutive symbols, rem_q left to go
//   ST_DONE  | burst finished or capped; idle until next position 0
module symbol_error_channel
    import rs_channel_pkg::*;
#(
    parameter int                SYM_W     = 8,
    parameter int                BLOCK_LEN = 255,
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(DEF_LFSR_TAPS),
    parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_W'(DEF_LFSR_SEED),
    parameter int                CNT_W     = 8
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    input  logic [1:0]           mode,
    input  logic [LFSR_W-1:0]    threshold,
    input  logic [CNT_W-1:0]     max_errs,
    input  logic [CNT_W-1:0]     burst_len,
    symbol_error_channel_if.slave ch,
    output logic [CNT_W-1:0]     blk_errs,
    output logic [31:0]          total_errs,
    output logic                 clk_out
);

    localparam int POS_W = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(BLOCK_LEN - 1);

    logic [LFSR_W-1:0] lfsr;
    logic [POS_W-1:0]  pos_q;
    mode_e             mode_q;
    logic [LFSR_W-1:0] thr_q;
    logic [CNT_W-1:0]  max_q;
    logic [CNT_W-1:0]  blen_q;

    burst_st_e         state_q, state_d, st_sel;
    logic [POS_W-1:0]  start_q, start_d, start_now, start_sel;
    logic [CNT_W-1:0]  rem_q, rem_d, rem_sel;

    logic              sop_in;
    mode_e             mode_eff;
    logic [LFSR_W-1:0] thr_eff;
    logic [CNT_W-1:0]  max_eff;
    logic [CNT_W-1:0]  blen_eff;
    logic [CNT_W-1:0]  cnt_cur;
    logic              cap_ok;
    logic              burst_hit;
    logic              inject;
    logic [SYM_W-1:0]  err_val;

    assign clk_out = clk_in;

    lfsr_gen #(
        .W    (LFSR_W),
        .TAPS (LFSR_TAPS),
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .en     (ch.in_valid),
        .state  (lfsr)
    );

    // The position-0 symbol already sees the freshly presented configuration.
    always_comb begin
        sop_in    = (pos_q == '0);
        mode_eff  = sop_in ? mode_e'(mode) : mode_q;
        thr_eff   = sop_in ? threshold : thr_q;
        max_eff   = sop_in ? max_errs  : max_q;
        blen_eff  = sop_in ? burst_len : blen_q;
        cnt_cur   = sop_in ? '0 : blk_errs;
        cap_ok    = (cnt_cur < max_eff);
        start_now = POS_W'(32'(lfsr[7:0]) % BLOCK_LEN);
        err_val   = (lfsr[SYM_W-1:0] == '0) ? SYM_W'(1) : lfsr[SYM_W-1:0];
    end

    always_comb begin
        state_d   = state_q;
        start_d   = start_q;
        rem_d     = rem_q;
        burst_hit = 1'b0;
        start_sel = sop_in ? start_now : start_q;
        rem_sel   = sop_in ? blen_eff  : rem_q;
        st_sel    = sop_in ? ST_WAIT   : state_q;
        if (ch.in_valid) begin
            if (mode_eff != MODE_BURST) begin
                state_d = ST_IDLE;
            end else begin
                if (sop_in) begin
                    state_d = ST_WAIT;
                    start_d = start_now;
                    rem_d   = blen_eff;
                end
                case (st_sel)
                    ST_WAIT: begin
                        if (pos_q == start_sel) begin
                            if (rem_sel != '0 && cap_ok) begin
                                burst_hit = 1'b1;
                                rem_d     = rem_sel - CNT_W'(1);
                                state_d   = (rem_sel == CNT_W'(1)) ? ST_DONE : ST_BURST;
                            end else begin
                                state_d = ST_DONE;
                            end
                        end
                    end
                    ST_BURST: begin
                        if (rem_sel != '0 && cap_ok) begin
                            burst_hit = 1'b1;
                            rem_d     = rem_sel - CNT_W'(1);
                            state_d   = (rem_sel == CNT_W'(1)) ? ST_DONE : ST_BURST;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        inject = 1'b0;
        case (mode_eff)
            MODE_RANDOM: inject = ch.in_valid && cap_ok && (lfsr < thr_eff);
            MODE_BURST:  inject = burst_hit;
            MODE_FIXED:  inject = ch.in_valid && cap_ok && (32'(pos_q) < 32'(max_eff));
            default:     inject = 1'b0;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            start_q <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            rem_q   <= rem_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            ch.out_valid <= 1'b0;
            ch.out_data  <= '0;
            ch.out_err   <= 1'b0;
            ch.out_sop   <= 1'b0;
            blk_errs     <= '0;
            total_errs   <= '0;
            pos_q        <= '0;
            mode_q       <= MODE_BYPASS;
            thr_q        <= '0;
            max_q        <= '0;
            blen_q       <= '0;
        end else begin
            ch.out_valid <= ch.in_valid;
            ch.out_data  <= ch.in_data ^ (inject ? err_val : '0);
            ch.out_err   <= inject;
            ch.out_sop   <= ch.in_valid && sop_in;
            if (ch.in_valid) begin
                pos_q <= (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
                if (sop_in) begin
                    mode_q   <= mode_eff;
                    thr_q    <= threshold;
                    max_q    <= max_errs;
                    blen_q   <= burst_len;
                    blk_errs <= inject ? CNT_W'(1) : '0;
                end else if (inject) begin
                    blk_errs <= blk_errs + CNT_W'(1);
                end
                if (inject && total_errs != 32'hFFFF_FFFF) begin
                    total_errs <= total_errs + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_symbol_error_channel.sv
// Randomised bench for symbol_error_channel: a per-symbol reference model of the
// channel rules is compared against the DUT every cycle, plus literal anchors.
module tb_symbol_error_channel;

    logic        clk_in = 1'b0;
    logic        rst_n  = 1'b0;
    logic [1:0]  mode   = 2'd0;
    logic [15:0] threshold = 16'h0;
    logic [7:0]  max_errs  = 8'd0;
    logic [7:0]  burst_len = 8'd0;
    logic [7:0]  blk_errs;
    logic [31:0] total_errs;
    logic        clk_out;

    symbol_error_channel_if #(.SYM_W(8)) ch ();

    symbol_error_channel #(
        .SYM_W     (8),
        .BLOCK_LEN (255),
        .LFSR_W    (16),
        .LFSR_TAPS (16'hB400),
        .LFSR_SEED (16'hACE1),
        .CNT_W     (8)
    ) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .mode       (mode),
        .threshold  (threshold),
        .max_errs   (max_errs),
        .burst_len  (burst_len),
        .ch         (ch),
        .blk_errs   (blk_errs),
        .total_errs (total_errs),
        .clk_out    (clk_out)
    );

    always #5 clk_in = ~clk_in;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    // Reference model: the channel rules applied one accepted symbol at a time.
    bit          armed = 0;
    logic [15:0] m_lfsr;
    int          m_pos, m_cnt, m_start, m_max, m_blen;
    logic [1:0]  m_mode;
    logic [15:0] m_thr;
    logic [31:0] m_total;
    logic        exp_valid, exp_err, exp_sop, exp_data_chk;
    logic [7:0]  exp_data;

    always @(posedge clk_in) begin
        logic [7:0] e;
        logic       hit, inj;
        if (!rst_n) begin
            armed = 1;
            m_lfsr = 16'hACE1; m_pos = 0; m_cnt = 0; m_total = 0; m_start = 0;
            m_mode = 0; m_thr = 0; m_max = 0; m_blen = 0;
            exp_valid = 0; exp_err = 0; exp_sop = 0; exp_data = 8'h00; exp_data_chk = 1;
        end else begin
            exp_valid = ch.in_valid; exp_err = 0; exp_sop = 0; exp_data_chk = ch.in_valid;
            if (ch.in_valid) begin
                if (m_pos == 0) begin
                    m_mode = mode; m_thr = threshold; m_max = int'(max_errs);
                    m_blen = int'(burst_len); m_cnt = 0;
                    m_start = int'(m_lfsr[7:0]) % 255;
                end
                e = m_lfsr[7:0];
                if (e == 8'h00) e = 8'h01;
                case (m_mode)
                    2'd1:    hit = (m_lfsr < m_thr);
                    2'd2:    hit = (m_pos >= m_start) && (m_pos < m_start + m_blen);
                    2'd3:    hit = (m_pos < m_max);
                    default: hit = 1'b0;
                endcase
                inj = hit && (m_cnt < m_max);
                exp_data = ch.in_data ^ (inj ? e : 8'h00);
                exp_err  = inj;
                exp_sop  = (m_pos == 0);
                if (inj) begin
                    m_cnt++;
                    if (m_total != 32'hFFFF_FFFF) m_total++;
                end
                m_lfsr = lfsr_next(m_lfsr);
                m_pos  = (m_pos == 254) ? 0 : m_pos + 1;
            end
        end
    end

    always @(posedge clk_in) begin
        #2;
        if (armed) begin
            chk("out_valid", 32'(ch.out_valid), 32'(exp_valid));
            chk("out_err", 32'(ch.out_err), 32'(exp_err));
            chk("out_sop", 32'(ch.out_sop), 32'(exp_sop));
            if (exp_data_chk) chk("out_data", 32'(ch.out_data), 32'(exp_data));
            chk("blk_errs", 32'(blk_errs), 32'(m_cnt[7:0]));
            chk("total_errs", total_errs, m_total);
        end
    end

    task automatic send(input logic v, input logic [7:0] d);
        @(negedge clk_in);
        ch.in_valid = v;
        ch.in_data  = d;
        @(posedge clk_in);
        #3;
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst_n = 1'b0;
        ch.in_valid = 1'b0;
        ch.in_data  = 8'h00;
        @(posedge clk_in);
        #3;
        rst_n = 1'b1;
    endtask

    task automatic cfg(input logic [1:0] md, input logic [15:0] th, input logic [7:0] mx, input logic [7:0] bl);
        mode = md; threshold = th; max_errs = mx; burst_len = bl;
    endtask

    initial begin
        ch.in_valid = 1'b0;
        ch.in_data  = 8'h00;

        // Reset values
        do_reset();
        chk("rst out_valid", 32'(ch.out_valid), 32'd0);
        chk("rst out_data", 32'(ch.out_data), 32'd0);
        chk("rst blk_errs", 32'(blk_errs), 32'd0);
        chk("rst total_errs", total_errs, 32'd0);

        // Fixed mode: first errors are the seed-derived values 0xE1, 0x70
        cfg(2'd3, 16'h0, 8'd16, 8'd0);
        send(1, 8'h00);
        chk("fixed first data", 32'(ch.out_data), 32'hE1);
        chk("fixed first err", 32'(ch.out_err), 32'd1);
        chk("fixed first sop", 32'(ch.out_sop), 32'd1);
        send(1, 8'h00);
        chk("fixed second data", 32'(ch.out_data), 32'h70);
        for (int i = 2; i < 255; i++) send(1, 8'h00);
        chk("fixed blk_errs end", 32'(blk_errs), 32'd16);

        // Bypass
        do_reset();
        cfg(2'd0, 16'hFFFF, 8'd255, 8'd20);
        for (int i = 0; i < 510; i++) send(1, 8'(i % 254));
        chk("bypass total", total_errs, 32'd0);

        // Random with cap
        do_reset();
        cfg(2'd1, 16'hFFFF, 8'd8, 8'd0);
        for (int i = 0; i < 765; i++) send(1, 8'($urandom));
        chk("random cap total", total_errs, 32'd24);

        // Burst variants including truncation, zero length and cap
        do_reset();
        cfg(2'd2, 16'h0, 8'd255, 8'd20);
        for (int i = 0; i < 255 * 6; i++) send(1, 8'($urandom));
        cfg(2'd2, 16'h0, 8'd255, 8'd200);
        for (int i = 0; i < 255 * 4; i++) send(1, 8'($urandom));
        cfg(2'd2, 16'h0, 8'd255, 8'd0);
        for (int i = 0; i < 255 * 2; i++) send(1, 8'($urandom));
        cfg(2'd2, 16'h0, 8'd5, 8'd30);
        for (int i = 0; i < 255 * 2; i++) send(1, 8'($urandom));

        // Valid gaps with random mode
        do_reset();
        cfg(2'd1, 16'h3000, 8'd10, 8'd0);
        for (int i = 0; i < 1200; i++) send(1'($urandom_range(0, 1)), 8'($urandom));

        // Reset mid-block
        do_reset();
        cfg(2'd3, 16'h0, 8'd4, 8'd0);
        for (int i = 0; i < 100; i++) send(1, 8'($urandom));
        @(negedge clk_in);
        rst_n = 1'b0;
        ch.in_valid = 1'b1;
        ch.in_data  = 8'h5A;
        @(posedge clk_in);
        #3;
        chk("midrst out_valid", 32'(ch.out_valid), 32'd0);
        chk("midrst out_data", 32'(ch.out_data), 32'd0);
        chk("midrst out_err", 32'(ch.out_err), 32'd0);
        chk("midrst out_sop", 32'(ch.out_sop), 32'd0);
        chk("midrst blk_errs", 32'(blk_errs), 32'd0);
        chk("midrst total", total_errs, 32'd0);
        rst_n = 1'b1;
        send(1, 8'h00);
        chk("post rst sop", 32'(ch.out_sop), 32'd1);
        chk("post rst data", 32'(ch.out_data), 32'hE1);
        send(1, 8'h00);
        chk("post rst data2", 32'(ch.out_data), 32'h70);

        // Free-running random configuration churn across all modes
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 63) == 0) begin
                cfg(2'($urandom_range(0, 3)), 16'($urandom),
                    ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom_range(0, 20)),
                    8'($urandom_range(0, 40)));
            end
            send(($urandom_range(0, 3) != 0), 8'($urandom));
        end

        send(0, 8'h00);
        send(0, 8'h00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/symbol_error_channel.md
Name: symbol_error_channel

Overview:
- Parametrised successor to the serial bit-error channel: injects symbol errors into a valid-qualified, SYM_W-wide symbol stream between the Reed-Solomon encoder and decoder.
- Tracks codeword boundaries (BLOCK_LEN symbols) and supports bypass, random, burst and fixed-position modes.
- Enforces a per-codeword error cap.
- Reports per-block and running error counts so the bench can check decoder correction limits.

Parameters:
- SYM_W, 8, symbol width in bits (RS over GF(2^8)).
- BLOCK_LEN, 255, symbols per codeword; position counter wraps after BLOCK_LEN-1.
- LFSR_W, 16, pseudorandom generator width.
- LFSR_TAPS, 16'hB400, Galois feedback tap mask (maximal length for 16 bits).
- LFSR_SEED, 16'hACE1, reset value; must be non-zero.
- CNT_W, 8, width of the per-block error cap, burst length and per-block counter.

Ports:
- clk_in  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- mode  in  2  0 bypass, 1 random, 2 burst, 3 fixed.
- threshold  in  LFSR_W  random mode: inject when lfsr < threshold.
- max_errs  in  CNT_W  per-codeword error cap (all modes except bypass).
- burst_len  in  CNT_W  burst mode: consecutive symbols corrupted.
- in_valid  in  1  input symbol qualifier.
- in_data  in  SYM_W  input symbol.
- out_valid  out  1  output symbol qualifier.
- out_data  out  SYM_W  output symbol, possibly corrupted.
- out_err  out  1  high with out_valid when out_data was corrupted.
- out_sop  out  1  high with the first symbol of each codeword.
- blk_errs  out  CNT_W  errors injected in the current codeword; cleared at each out_sop.
- total_errs  out  32  running error total; saturates at 32'hFFFFFFFF.
- clk_out  out  1  equal to clk_in (pass-through for the downstream decoder).

Behaviour:
- Reset (rst_n low at a clk_in edge):
  - out_valid=0, out_data=0, out_err=0, out_sop=0, blk_errs=0, total_errs=0.
  - lfsr=LFSR_SEED, position=0, FSM=IDLE.
  - Reset mid-codeword discards the partial block; the next accepted symbol is position 0.
- Latency: exactly 1 cycle. out_valid(t+1)=in_valid(t). There is no backpressure; in_valid may toggle freely.
- All state (lfsr, position, FSM, counters) advances only on cycles with in_valid=1. Gaps in in_valid do not alter the injection pattern.
- Latching: mode, threshold, max_errs and burst_len are latched on the position-0 symbol. Changes mid-codeword take effect at the next codeword.
- Error value: e = lfsr[SYM_W-1:0]; if e==0, e=1. The corrupted symbol is in_data XOR e, so a corrupted symbol always differs from the input.
- Cap: no injection while blk_errs == latched max_errs. max_errs=0 is therefore equivalent to bypass.
- Mode 0, bypass: data passes unchanged, out_err=0.
- Mode 1, random: inject when lfsr < threshold and the cap is not reached. threshold=0 gives no errors; threshold=2^LFSR_W-1 corrupts every symbol up to the cap.
- Mode 2, burst FSM with states IDLE, WAIT, BURST, DONE:
  - IDLE->WAIT at position 0; start = lfsr[7:0] mod BLOCK_LEN.
  - WAIT->BURST when position==start.
  - BURST corrupts symbols while remaining>0 and the cap is not reached, then goes to DONE.
  - A burst reaching the end of the codeword is truncated; it does not spill into the next block.
  - DONE->WAIT at the next position 0, where a new start is drawn.
  - burst_len=0 never enters BURST.
- Mode 3, fixed: corrupt positions 0..max_errs-1. This is deterministic for the decoder t-limit check.
- Counters:
  - blk_errs increments with each out_err and is reset to 0 or 1 on out_sop.
  - total_errs increments with each out_err and saturates.
- Position: wraps from BLOCK_LEN-1 to 0; out_sop is asserted with the registered position-0 symbol.
- LFSR: Galois form, shifts once per accepted symbol. The all-zero state is unreachable from the non-zero seed.

Decomposition:
- Shared package (rs_channel_pkg):
  - mode encodings MODE_BYPASS/RANDOM/BURST/FIXED;
  - burst FSM state enum;
  - default LFSR taps and seed constants.
- Natural sub-module: lfsr_gen (parametrised width/taps/seed, enable input, parallel state output), reusable by other test-pattern blocks.
- Injection, FSM and counters stay in the top module.

Test Plan:
- Bypass: mode=0, 510 symbols 0x00..0xFD repeating -> out_data==in_data delayed 1 cycle, out_err never high, total_errs=0, out_sop on symbols 0 and 255.
- Fixed: mode=3, max_errs=16, all-zero input -> positions 0..15 nonzero with out_err=1, positions 16..254 zero, blk_errs=16 at block end.
- Random cap: mode=1, threshold=16'hFFFF, max_errs=8 -> exactly 8 errors at positions 0..7 per codeword; total_errs=24 after 3 codewords.
- Burst truncation: mode=2, burst_len=20, max_errs=255 -> 20 consecutive errors, or fewer ending exactly at position 254; none at the next block's position 0 unless it is a new burst start.
- Valid gaps: same seed, stream sent with in_valid toggling 1-0-1 -> error positions and values identical to the gapless run.
- Reset mid-block: assert rst_n=0 at position 100 -> next cycle all outputs 0; next accepted symbol has out_sop=1 and the LFSR sequence restarts from 16'hACE1.
